// File: rtl/ram_bus_ctrl.sv
// Sequential master for a single-port RAM on a shared tri-state data bus.
// Writes drive the bus for one cycle; reads enable the RAM driver, wait READ_LATENCY cycles, then sample.
module ram_bus_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic                  bus_we_o,
  output logic                  bus_oe_o,
  inout  wire  [DATA_WIDTH-1:0] bus_data
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_REL  = 3'd2,
    S_RD_TURN = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RD_REL  = 3'd5
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rvalid_q;
  logic                    bus_we_q;
  logic                    bus_oe_q;

  // Handshake: a request is taken on a rising edge where req_i=1 and ready_o=1;
  // all request fields are captured on that edge and inputs are ignored until ready_o returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      bus_we_q <= 1'b0;
      bus_oe_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            we_q    <= we_i;
            if (we_i) begin
              state_q  <= S_WR;
              bus_we_q <= 1'b1;
            end else begin
              state_q  <= S_RD_TURN;
            end
          end
        end
        S_WR: begin
          state_q  <= S_WR_REL;
          bus_we_q <= 1'b0;
        end
        S_WR_REL: begin
          state_q <= S_IDLE;
        end
        S_RD_TURN: begin
          state_q  <= S_RD_WAIT;
          bus_oe_q <= 1'b1;
          cnt_q    <= CNT_LOAD;
        end
        S_RD_WAIT: begin
          if (cnt_q == '0) begin
            state_q  <= S_RD_REL;
            bus_oe_q <= 1'b0;
            rdata_q  <= bus_data;
            rvalid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RD_REL: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          bus_we_q <= 1'b0;
          bus_oe_q <= 1'b0;
        end
      endcase
    end
  end

  // Drive is decoded from state so an async reset releases the bus immediately.
  assign bus_data   = (state_q == S_WR && we_q) ? wdata_q : {DATA_WIDTH{1'bz}};
  assign ready_o    = (state_q == S_IDLE);
  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign bus_addr_o = addr_q;
  assign bus_we_o   = bus_we_q;
  assign bus_oe_o   = bus_oe_q;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Randomized bench for ram_bus_ctrl: a RAM model on the shared bus, a reference memory,
// and a monitor that pops expected writes, read data and handshake timing from queues.
module tb_ram_bus_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_i = 1'b0;
  logic          we_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic          ready_o, rvalid_o, bus_we_o, bus_oe_o;
  logic [DW-1:0] rdata_o;
  logic [AW-1:0] bus_addr_o;
  wire  [DW-1:0] bus_data;

  logic [DW-1:0] ram_mem [2**AW];
  logic [DW-1:0] ref_mem [2**AW];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int rv_cnt = 0;
  int wr_cnt = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_rv_cyc_q[$];
  logic [DW-1:0] wexp_q[$];
  logic [AW-1:0] waddr_q[$];
  int            rdy_cyc_q[$];
  logic [AW-1:0] cur_addr = '0;

  ram_bus_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ready_o(ready_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_oe_o(bus_oe_o),
    .bus_data(bus_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- RAM model ----------------
  assign bus_data = bus_oe_o ? ram_mem[bus_addr_o] : {DW{1'bz}};
  always @(negedge clk) if (!rst && bus_we_o) ram_mem[bus_addr_o] = bus_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic released();
    return (bus_data === {DW{1'bz}}) || (bus_data === {DW{1'b0}});
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic          prev_ready, prev_we, prev_oe, prev_rv;
  logic [DW-1:0] last_rdata;
  int            oe_len, dead, last_drv;
  initial begin
    prev_ready = 1'b1; prev_we = 1'b0; prev_oe = 1'b0; prev_rv = 1'b0;
    last_rdata = '0; oe_len = 0; dead = 0; last_drv = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b1; prev_we = 1'b0; prev_oe = 1'b0; prev_rv = 1'b0;
      last_rdata = '0; oe_len = 0; dead = 0; last_drv = 0;
    end else begin
      if (bus_we_o || bus_oe_o) check("no_contention", 32'(bus_we_o & bus_oe_o), 0);
      if (!bus_we_o && !bus_oe_o) check("bus_released", 32'(released()), 1);
      if (!ready_o) check("bus_addr_hold", 32'(bus_addr_o), 32'(cur_addr));
      if (bus_we_o) begin
        wr_cnt++;
        check("we_one_cycle", 32'(prev_we), 0);
        if (wexp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          check("write_data", 32'(bus_data), 32'(wexp_q.pop_front()));
          check("write_addr", 32'(bus_addr_o), 32'(waddr_q.pop_front()));
        end
        if (!prev_we && last_drv == 2) check("dead_rd_to_wr", 32'(dead >= 1), 1);
        last_drv = 1; dead = 0;
      end
      if (bus_oe_o) begin
        if (!prev_oe && last_drv == 1) check("dead_wr_to_rd", 32'(dead >= 2), 1);
        last_drv = 2; dead = 0; oe_len++;
      end
      if (!bus_we_o && !bus_oe_o) dead++;
      if (prev_oe && !bus_oe_o) begin
        check("oe_len", oe_len, RL);
        oe_len = 0;
      end
      if (rvalid_o) begin
        rv_cnt++;
        check("rvalid_one_cycle", 32'(prev_rv), 0);
        if (exp_q.size() == 0) check("unexpected_rvalid", 1, 0);
        else begin
          check("read_data", 32'(rdata_o), 32'(exp_q.pop_front()));
          check("rvalid_time", cyc, exp_rv_cyc_q.pop_front());
        end
        last_rdata = rdata_o;
      end else begin
        check("rdata_hold", 32'(rdata_o), 32'(last_rdata));
      end
      if (ready_o && !prev_ready) begin
        if (rdy_cyc_q.size() == 0) check("unexpected_ready", 1, 0);
        else check("ready_return", cyc, rdy_cyc_q.pop_front());
      end
      prev_ready = ready_o; prev_we = bus_we_o; prev_oe = bus_oe_o; prev_rv = rvalid_o;
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge right after acceptance with req_i low.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit rdy;
    bit accepted;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    accepted = 1'b0;
    for (int n = 0; n < 50 && !accepted; n++) begin
      rdy = ready_o;
      @(posedge clk);
      #1;
      if (rdy) accepted = 1'b1;
      else @(negedge clk);
    end
    if (!accepted) check("accept_timeout", 0, 1);
    else begin
      cur_addr = a;
      if (we) begin
        ref_mem[a] = d;
        wexp_q.push_back(d);
        waddr_q.push_back(a);
        rdy_cyc_q.push_back(cyc + 2);
      end else begin
        exp_q.push_back(ref_mem[a]);
        exp_rv_cyc_q.push_back(cyc + RL + 1);
        rdy_cyc_q.push_back(cyc + RL + 2);
      end
    end
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(ready_o),    1);
    check({tag, "_we"},     32'(bus_we_o),   0);
    check({tag, "_oe"},     32'(bus_oe_o),   0);
    check({tag, "_rvalid"}, 32'(rvalid_o),   0);
    check({tag, "_rdata"},  32'(rdata_o),    0);
    check({tag, "_bus_z"},  32'(released()), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int before_rv, before_wr;
    logic [DW-1:0] v;
    for (int i = 0; i < 2**AW; i++) begin
      v = DW'($urandom_range(0, 255));
      ram_mem[i] = v;
      ref_mem[i] = v;
    end

    #2;
    check_reset_outputs("por");
    check("por_addr", 32'(bus_addr_o), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // mid-cycle reset while idle
    @(posedge clk); #2 rst = 1'b1;
    #1 check_reset_outputs("idle_rst");
    @(negedge clk); @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);

    // directed write then separate read
    issue(1'b1, 4'h3, 8'hA5);
    repeat (3) @(negedge clk);
    issue(1'b0, 4'h3, 8'h00);
    repeat (5) @(negedge clk);

    // back-to-back write then read
    issue(1'b1, 4'h5, 8'h3C);
    issue(1'b0, 4'h5, 8'h00);
    repeat (6) @(negedge clk);

    // request churn during a read
    before_rv = rv_cnt; before_wr = wr_cnt;
    issue(1'b0, 4'h7, 8'h00);
    for (int k = 0; k < RL + 2; k++) begin
      req_i   = k[0] ? 1'b0 : 1'b1;
      we_i    = 1'($urandom_range(0, 1));
      addr_i  = AW'($urandom_range(0, 15));
      wdata_i = DW'($urandom_range(1, 255));
      @(negedge clk);
    end
    req_i = 1'b0;
    repeat (RL + 6) @(negedge clk);
    check("churn_rvalid_count", rv_cnt - before_rv, 1);
    check("churn_write_count", wr_cnt - before_wr, 0);

    // reset in the second read-wait cycle
    before_rv = rv_cnt;
    issue(1'b0, 4'h9, 8'h00);
    @(posedge clk); @(posedge clk); #3 rst = 1'b1;
    #1 check_reset_outputs("abort_rst");
    exp_q.delete(); exp_rv_cyc_q.delete(); rdy_cyc_q.delete();
    @(negedge clk); @(negedge clk); #1 rst = 1'b0;
    repeat (RL + 4) @(negedge clk);
    check("abort_no_rvalid", rv_cnt - before_rv, 0);
    issue(1'b0, 4'h9, 8'h00);
    repeat (RL + 4) @(negedge clk);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom_range(1, 255)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int w = 0; w < 200 && (exp_q.size() != 0 || rdy_cyc_q.size() != 0 || wexp_q.size() != 0); w++)
      @(negedge clk);
    check("drain_exp_q", exp_q.size(), 0);
    check("drain_rdy_q", rdy_cyc_q.size(), 0);
    check("drain_wr_q", wexp_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ram_bus_ctrl.md
Name: ram_bus_ctrl

Overview:
- Sequential master for an external single-port RAM that shares one bidirectional, tri-stated data bus.
- Owns the controller side of the bus. It drives the bus only during writes and releases it (high-Z) otherwise.
- On reads it enables the RAM's output driver, waits a fixed latency, then samples the bus.
- Enforces one dead turnaround cycle so that the controller and the RAM never drive the bus in the same cycle.

Parameters:
- DATA_WIDTH, 8, width of bus_data, wdata_i and rdata_o.
- ADDR_WIDTH, 4, width of addr_i and bus_addr_o.
- READ_LATENCY, 2, cycles bus_oe_o is held high before sampling; legal range is 1 or more.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_i  input  1  transaction request; accepted on a rising edge where req_i=1 and ready_o=1.
- we_i  input  1  1 = write, 0 = read; sampled at acceptance.
- addr_i  input  ADDR_WIDTH  address; sampled at acceptance.
- wdata_i  input  DATA_WIDTH  write data; sampled at acceptance.
- ready_o  output  1  high only in IDLE.
- rdata_o  output  DATA_WIDTH  last captured read data; holds until the next capture.
- rvalid_o  output  1  one-cycle pulse when rdata_o updates.
- bus_addr_o  output  ADDR_WIDTH  registered RAM address.
- bus_we_o  output  1  RAM write strobe.
- bus_oe_o  output  1  RAM output-driver enable.
- bus_data  inout  DATA_WIDTH  shared tri-state data bus.

Behaviour:
- Reset (async, immediate, regardless of state):
  - state = IDLE, bus_data released to all-Z.
  - bus_we_o = 0, bus_oe_o = 0, rvalid_o = 0.
  - rdata_o = 0, bus_addr_o = 0.
  - ready_o = 1 while and after reset.
- Outputs: all outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Bus drive: the controller drives bus_data only in state WR, with the registered wdata. In every other state bus_data is all-Z.
- Bus contention: bus_oe_o=1 never coincides with a state in which the controller drives bus_data. Every transition between controller drive and RAM drive passes through one cycle where both are off.
- Write path: IDLE --accept, we_i=1--> WR --> WR_REL --> IDLE.
  - WR lasts 1 cycle: bus_we_o=1, bus_data = wdata.
  - WR_REL lasts 1 cycle: bus_we_o=0, bus released.
  - ready_o returns high on the 2nd edge after acceptance.
- Read path: IDLE --accept, we_i=0--> RD_TURN --> RD_WAIT --> RD_REL --> IDLE.
  - RD_TURN lasts 1 cycle: both drivers off.
  - RD_WAIT lasts READ_LATENCY cycles: bus_oe_o=1. A down-counter loads READ_LATENCY-1 on entry.
  - On the edge that leaves RD_WAIT: rdata_o <= bus_data, rvalid_o <= 1.
  - RD_REL lasts 1 cycle: bus_oe_o=0, rvalid_o=1.
  - On the next edge rvalid_o <= 0 and the state returns to IDLE.
  - Timing: rvalid_o rises on edge READ_LATENCY+1 after acceptance; ready_o returns on edge READ_LATENCY+2.
- Registered request fields: bus_addr_o and the internal wdata/we registers load only on acceptance. They hold through the transaction and afterwards.
- Ignored inputs: req_i, we_i, addr_i and wdata_i are ignored while ready_o=0. There is no queuing and no error flag.
- Back-to-back: a request held high in IDLE is accepted immediately on return to IDLE, with no extra idle cycle. Write followed by read still inserts WR_REL, then RD_TURN, giving 2 bus-dead cycles.
- Bus Z on capture: if bus_data is Z/X at capture, rdata_o takes that value. The controller does not check it.
- Reset mid-transaction:
  - bus_oe_o and bus_we_o drop asynchronously and the bus is released immediately.
  - No rvalid_o pulse is produced for the aborted read.
  - rdata_o returns to 0.
- Illegal or unused state encodings recover to IDLE on the next edge with all drivers off.

Test Plan:
- Reset then idle: assert rst mid-cycle -> immediately ready_o=1, bus_data=Z, bus_we_o=0, bus_oe_o=0, rdata_o=0, rvalid_o=0.
- Write addr 4'h3, data 8'hA5 -> next cycle bus_addr_o=3, bus_we_o=1, bus_data=A5 for exactly 1 cycle; then 1 cycle of Z with ready_o=0; ready_o=1 on edge 2.
- Read addr 4'h3, RAM model driving 8'hA5 when bus_oe_o=1, READ_LATENCY=2 -> 1 dead cycle, bus_oe_o high 2 cycles, rvalid_o pulses 1 cycle on edge 3 with rdata_o=A5; ready_o on edge 4.
- Write 8'h3C then immediate read with req_i held -> bus monitor flags no cycle where the controller drives while bus_oe_o=1; 2 Z cycles between the drivers; readback = 3C.
- Request churn while busy: toggle req_i, addr_i and wdata_i during a read -> bus_addr_o is unchanged and exactly one transaction completes.
- Reset asserted in the second RD_WAIT cycle -> bus_oe_o falls without waiting for a clock edge; no rvalid_o pulse; rdata_o=0; the next read completes normally.
